// File: rtl/sat_mac_pkg.sv
// -----------------------------------------------------------------------------
// sat_mac_pkg
// Shared types and helpers for the saturating MAC datapath.
//   state_t  : control states (IDLE, ACC, OUT)
//   sym_max  : largest value of the symmetric signed range for a width w
//   sym_min  : -sym_max; -2^(w-1) is deliberately excluded from the range
//   sat_sym  : clamps a 64-bit signed value into [sym_min(w), sym_max(w)]
// -----------------------------------------------------------------------------
package sat_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic logic signed [63:0] sym_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sym_min(input int w);
    return -sym_max(w);
  endfunction

  function automatic logic signed [63:0] sat_sym(input logic signed [63:0] value,
                                                 input int w);
    if (value > sym_max(w)) return sym_max(w);
    if (value < sym_min(w)) return sym_min(w);
    return value;
  endfunction

endpackage

// File: rtl/sat_mul.sv
// -----------------------------------------------------------------------------
// sat_mul
// Stage-1 combinational product: clamp operands to the symmetric range,
// full-width signed multiply, arithmetic shift right by FRAC (floor),
// saturate back to W bits.
// Ports:
//   i_a, i_b : signed operands (W bits)
//   o_prod   : saturated, scaled product (W bits)
//   o_sat    : high when the product had to be saturated
// -----------------------------------------------------------------------------
module sat_mul
  import sat_mac_pkg::*;
#(
  parameter int W    = 8,
  parameter int FRAC = 0
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_prod,
  output logic                o_sat
);

  localparam logic signed [W-1:0] MIN_W   = W'(sym_min(W));
  localparam logic        [W-1:0] NEG_FS  = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0]   w_a;
  logic signed [W-1:0]   w_b;
  logic signed [2*W-1:0] w_full;
  logic signed [2*W-1:0] w_shift;
  logic signed [63:0]    w_ext;
  logic signed [63:0]    w_clip;

  // -2^(W-1) has no positive counterpart; fold it onto MIN before use
  assign w_a     = (i_a == NEG_FS) ? MIN_W : i_a;
  assign w_b     = (i_b == NEG_FS) ? MIN_W : i_b;
  assign w_full  = w_a * w_b;
  assign w_shift = w_full >>> FRAC;
  assign w_ext   = 64'(w_shift);
  assign w_clip  = sat_sym(w_ext, W);
  assign o_prod  = w_clip[W-1:0];
  assign o_sat   = (w_clip != w_ext);

endmodule

// File: rtl/sat_mac_acc.sv
// -----------------------------------------------------------------------------
// sat_mac_acc
// Pipelined saturating fixed-point MAC. Accumulates N_TERMS (a, b) pairs with
// per-term symmetric saturation and presents one result per neuron.
// Optional macro SAT_MAC_OVF_FLAG_EN adds the sticky 'ovf' output.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   in_valid/in_ready, in_a, in_b  : operand stream
//   out_valid/out_ready, out_sum   : result stream
//   ovf (macro only)               : any saturation within the current neuron
// Pipeline: stage 1 registers the product, stage 2 updates the accumulator;
// the FSM leaves ACC only after the last term has fully drained.
// -----------------------------------------------------------------------------
module sat_mac_acc
  import sat_mac_pkg::*;
#(
  parameter int W       = 8,
  parameter int FRAC    = 0,
  parameter int N_TERMS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_a,
  input  logic signed [W-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_sum
`ifdef SAT_MAC_OVF_FLAG_EN
  ,
  output logic                ovf
`endif
);

  localparam int            CW    = $clog2(N_TERMS + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N_TERMS);

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic signed [W-1:0] r_prod;
  logic signed [W-1:0] r_acc;
  logic                r_pvld;
  logic signed [W-1:0] w_prod;
  logic                w_prod_sat;
  logic                w_in_fire;
  logic                w_out_fire;
  logic signed [W:0]   w_sum;
  logic signed [63:0]  w_sum_ext;
  logic signed [63:0]  w_sum_clip;
  logic                w_sum_sat;

  sat_mul #(.W(W), .FRAC(FRAC)) u_mul (
    .i_a    (in_a),
    .i_b    (in_b),
    .o_prod (w_prod),
    .o_sat  (w_prod_sat)
  );

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // W+1 bits cannot overflow for two in-range W-bit operands
  assign w_sum      = {r_acc[W-1], r_acc} + {r_prod[W-1], r_prod};
  assign w_sum_ext  = 64'(w_sum);
  assign w_sum_clip = sat_sym(w_sum_ext, W);
  assign w_sum_sat  = (w_sum_clip != w_sum_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_in_fire) w_next = ACC;
      ACC:     if ((r_cnt == N_CNT) && !r_pvld) w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE:    in_ready  = 1'b1;
        ACC:     in_ready  = (r_cnt < N_CNT);
        OUT:     out_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_prod <= '0;
      r_pvld <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_pvld <= w_in_fire;
      if (w_in_fire) begin
        r_prod <= w_prod;
        r_cnt  <= r_cnt + CW'(1);
      end
      // out handshake only happens with the pipeline empty, so no overlap
      if (r_pvld) begin
        r_acc <= w_sum_clip[W-1:0];
      end else if (w_out_fire) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end

  assign out_sum = r_acc;

`ifdef SAT_MAC_OVF_FLAG_EN
  logic r_prod_sat;
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod_sat <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_in_fire) r_prod_sat <= w_prod_sat;
      if (w_out_fire) r_ovf <= 1'b0;
      else if (r_pvld && (r_prod_sat || w_sum_sat)) r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_prod_sat ^ w_sum_sat;
`endif

endmodule
